// File: rtl/sram_rec_pkg.sv
// rtl/sram_rec_pkg.sv - shared types and default palettes for the SRAM frame recorder
package sram_rec_pkg;

  // Two-bit mode request as presented by the host
  typedef enum logic [1:0] {
    MODE_LIVE    = 2'b00,
    MODE_REC     = 2'b01,
    MODE_PLAY    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_LIVE     = 2'd0,
    ST_REC      = 2'd1,
    ST_PLAY     = 2'd2,
    ST_SHOT_REC = 2'd3
  } state_e;

  // {r,g,b} 3-bit palettes
  localparam logic [8:0] COL_LIVE_1_DEF = 9'o227;
  localparam logic [8:0] COL_LIVE_0_DEF = 9'o736;
  localparam logic [8:0] COL_PLAY_1_DEF = 9'o357;
  localparam logic [8:0] COL_PLAY_0_DEF = 9'o414;

  function automatic logic [8:0] pick_colour(input logic sel, input logic [8:0] col_1,
                                             input logic [8:0] col_0);
    return sel ? col_1 : col_0;
  endfunction

endpackage

// File: rtl/sram_frame_recorder_if.sv
// rtl/sram_frame_recorder_if.sv - raster/pixel input bundle from vga_sync and the RPi
// Signals: display_en (visible pixel), h_count/v_count (raster position),
//          pixel_in (1-bit colour sample), mode_req (00 LIVE, 01 REC, 10 PLAY, 11 ONESHOT).
// master drives the raster (timing generator / bench), slave consumes it (recorder).
interface sram_frame_recorder_if;
  logic        display_en;
  logic [11:0] h_count;
  logic [11:0] v_count;
  logic        pixel_in;
  logic [1:0]  mode_req;

  modport master (output display_en, h_count, v_count, pixel_in, mode_req);
  modport slave  (input  display_en, h_count, v_count, pixel_in, mode_req);
endinterface

// File: rtl/sram_cell_addr_gen.sv
// rtl/sram_cell_addr_gen.sv - raster counts to registered SRAM cell address and aligned phase
// Ports: clk_i, rst_i (async, active-high); display_en_i, h_count_i, v_count_i (raster);
//        sram_addr_o (registered cell address, 0 outside the visible area);
//        ph_o (h phase delayed to line up with sram_addr_o);
//        vis_o (combinational visible qualifier for the current raster position).
module sram_cell_addr_gen #(
  parameter int H_DISPLAY   = 800,
  parameter int V_DISPLAY   = 600,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 18
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   display_en_i,
  input  logic [11:0]            h_count_i,
  input  logic [11:0]            v_count_i,
  output logic [ADDR_W-1:0]      sram_addr_o,
  output logic [SCALE_SHIFT-1:0] ph_o,
  output logic                   vis_o
);

  localparam int LINE_W = H_DISPLAY >> SCALE_SHIFT;

  logic [31:0]            cell_full;
  logic                   vis_d;
  logic [ADDR_W-1:0]      sram_addr_d;
  logic [ADDR_W-1:0]      sram_addr_q;
  logic [SCALE_SHIFT-1:0] ph_d;
  logic [SCALE_SHIFT-1:0] ph_q;

  // Constant multiply; the result is truncated to ADDR_W so oversize rasters wrap.
  always_comb begin
    cell_full   = 32'(h_count_i >> SCALE_SHIFT)
                + 32'(v_count_i >> SCALE_SHIFT) * 32'(LINE_W);
    vis_d       = display_en_i && (32'(v_count_i) < 32'(V_DISPLAY));
    sram_addr_d = vis_d ? ADDR_W'(cell_full) : '0;
    ph_d        = h_count_i[SCALE_SHIFT-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sram_addr_q <= '0;
      ph_q        <= '0;
    end else begin
      sram_addr_q <= sram_addr_d;
      ph_q        <= ph_d;
    end
  end

  assign sram_addr_o = sram_addr_q;
  assign ph_o        = ph_q;
  assign vis_o       = vis_d;

endmodule

// File: rtl/sram_frame_recorder.sv
// rtl/sram_frame_recorder.sv - downscaled frame record/playback between vga_sync, RPi and async SRAM
// Ports: rpi_pixel_clock, rst (async, active-high); vid (raster/pixel/mode input bundle);
//        sram_addr, sram_io, sram_we_n, sram_oe_n, sram_cs_n (external 8-bit async SRAM);
//        r_out/g_out/b_out (registered colour); recording (REC or SHOT_REC);
//        frame_done (one-clock pulse when a one-shot capture ends).
module sram_frame_recorder
  import sram_rec_pkg::*;
#(
  parameter int         H_DISPLAY   = 800,
  parameter int         V_DISPLAY   = 600,
  parameter int         SCALE_SHIFT = 2,
  parameter int         ADDR_W      = 18,
  parameter int         DATA_W      = 8,
  parameter logic [8:0] COL_LIVE_1  = COL_LIVE_1_DEF,
  parameter logic [8:0] COL_LIVE_0  = COL_LIVE_0_DEF,
  parameter logic [8:0] COL_PLAY_1  = COL_PLAY_1_DEF,
  parameter logic [8:0] COL_PLAY_0  = COL_PLAY_0_DEF
) (
  input  logic                       rpi_pixel_clock,
  input  logic                       rst,
  sram_frame_recorder_if.slave       vid,
  output logic [ADDR_W-1:0]          sram_addr,
  inout  wire  [DATA_W-1:0]          sram_io,
  output logic                       sram_we_n,
  output logic                       sram_oe_n,
  output logic                       sram_cs_n,
  output logic [2:0]                 r_out,
  output logic [2:0]                 g_out,
  output logic [2:0]                 b_out,
  output logic                       recording,
  output logic                       frame_done
);

  localparam logic [SCALE_SHIFT-1:0] PH_LAST = '1;

  logic [SCALE_SHIFT-1:0] ph_raw;
  logic [SCALE_SHIFT-1:0] ph_al;
  logic                   vis;
  logic                   sof;
  mode_e                  req;

  state_e                 state_q;
  mode_e                  prev_req_q;
  logic                   frame_done_q;

  logic [DATA_W-1:0]      wdata_q;
  logic [DATA_W-1:0]      rd_word_q;
  logic                   drive_q;
  logic                   we_n_q;
  logic [8:0]             rgb_q;

  logic                   wr_state;
  logic                   wr_now;
  logic                   strobe;

  sram_cell_addr_gen #(
    .H_DISPLAY   (H_DISPLAY),
    .V_DISPLAY   (V_DISPLAY),
    .SCALE_SHIFT (SCALE_SHIFT),
    .ADDR_W      (ADDR_W)
  ) u_addr_gen (
    .clk_i        (rpi_pixel_clock),
    .rst_i        (rst),
    .display_en_i (vid.display_en),
    .h_count_i    (vid.h_count),
    .v_count_i    (vid.v_count),
    .sram_addr_o  (sram_addr),
    .ph_o         (ph_al),
    .vis_o        (vis)
  );

  assign ph_raw = vid.h_count[SCALE_SHIFT-1:0];
  assign sof    = vid.display_en && (vid.h_count == '0) && (vid.v_count == '0);
  assign req    = mode_e'(vid.mode_req);

  // Mode FSM: the request is only looked at on the start-of-frame tick, so a
  // frame is never split between two modes. The end of a one-shot capture
  // takes priority over whatever is requested on that tick.
  always_ff @(posedge rpi_pixel_clock or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LIVE;
      prev_req_q   <= MODE_LIVE;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (sof) begin
        prev_req_q <= req;
        if (state_q == ST_SHOT_REC) begin
          state_q      <= ST_PLAY;
          frame_done_q <= 1'b1;
        end else begin
          case (req)
            MODE_LIVE:    state_q <= ST_LIVE;
            MODE_REC:     state_q <= ST_REC;
            MODE_PLAY:    state_q <= ST_PLAY;
            // Only a fresh 11 arms a capture; a held 11 keeps the current state.
            MODE_ONESHOT: if (prev_req_q != MODE_ONESHOT) state_q <= ST_SHOT_REC;
            default:      state_q <= state_q;
          endcase
        end
      end
    end
  end

  // Write controls are registered from the raw counts so they land in the
  // same clock as the address they belong to. The strobe skips the first and
  // last phase of every cell, keeping address and data stable around it.
  assign wr_state = (state_q == ST_REC) || (state_q == ST_SHOT_REC);
  assign wr_now   = wr_state && vis;
  assign strobe   = wr_now && (ph_raw != '0) && (ph_raw != PH_LAST);

  always_ff @(posedge rpi_pixel_clock or posedge rst) begin
    if (rst) begin
      wdata_q   <= '0;
      drive_q   <= 1'b0;
      we_n_q    <= 1'b1;
      rd_word_q <= '0;
      rgb_q     <= '0;
    end else begin
      if (ph_raw == '0) wdata_q <= {DATA_W{vid.pixel_in}};
      drive_q <= wr_now;
      we_n_q  <= !strobe;
      // Last aligned phase of a cell: the read data has had the whole cell to settle.
      if ((ph_al == PH_LAST) && !drive_q) rd_word_q <= sram_io;
      if (!vid.display_en) begin
        rgb_q <= '0;
      end else if (state_q == ST_PLAY) begin
        rgb_q <= pick_colour(rd_word_q != '0, COL_PLAY_1, COL_PLAY_0);
      end else begin
        rgb_q <= pick_colour(vid.pixel_in, COL_LIVE_1, COL_LIVE_0);
      end
    end
  end

  assign sram_io    = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign sram_we_n  = we_n_q;
  assign sram_oe_n  = drive_q;
  assign sram_cs_n  = 1'b0;
  assign r_out      = rgb_q[8:6];
  assign g_out      = rgb_q[5:3];
  assign b_out      = rgb_q[2:0];
  assign recording  = wr_state;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sram_frame_recorder.sv
// tb/tb_sram_frame_recorder.sv - self-checking bench for sram_frame_recorder
module tb_sram_frame_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [7:0]  sram_io;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, cs_n;
  logic [2:0]  r, g, b;
  logic        recording, frame_done;
  logic [8:0]  rgb;
  logic [7:0]  mem [0:1023];

  int checks = 0;
  int errors = 0;
  int we_cnt;
  int fd_cnt;

  always #5 clk = ~clk;

  sram_frame_recorder_if vid();

  sram_frame_recorder dut (
    .rpi_pixel_clock (clk),
    .rst             (rst),
    .vid             (vid),
    .sram_addr       (sram_addr),
    .sram_io         (sram_io),
    .sram_we_n       (we_n),
    .sram_oe_n       (oe_n),
    .sram_cs_n       (cs_n),
    .r_out           (r),
    .g_out           (g),
    .b_out           (b),
    .recording       (recording),
    .frame_done      (frame_done)
  );

  assign rgb = {r, g, b};

  // Async SRAM model: reads while output-enabled, writes while the strobe is low.
  assign sram_io = (!oe_n && we_n) ? mem[sram_addr[9:0]] : 8'hzz;
  always @(posedge clk) if (!we_n) mem[sram_addr[9:0]] <= sram_io;

  typedef struct {
    logic [11:0] h;
    logic        pix;
    logic [17:0] addr;
    logic        we_n;
    logic        oe_n;
    logic [7:0]  io;
    logic [8:0]  rgb;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic de, input logic [11:0] h, input logic [11:0] v,
                     input logic pix, input logic [1:0] req);
    vid.display_en = de;
    vid.h_count    = h;
    vid.v_count    = v;
    vid.pixel_in   = pix;
    vid.mode_req   = req;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Line 0 in REC with a 4-pixel checkerboard (cells 0,2 = 1; 1,3 = 0).
    vecs[0]  = '{12'd0,  1'b1, 18'd0, 1'b1, 1'b0, 8'h00, 9'o227};
    vecs[1]  = '{12'd1,  1'b1, 18'd0, 1'b0, 1'b1, 8'hff, 9'o227};
    vecs[2]  = '{12'd2,  1'b1, 18'd0, 1'b0, 1'b1, 8'hff, 9'o227};
    vecs[3]  = '{12'd3,  1'b1, 18'd0, 1'b1, 1'b1, 8'hff, 9'o227};
    vecs[4]  = '{12'd4,  1'b0, 18'd1, 1'b1, 1'b1, 8'h00, 9'o736};
    vecs[5]  = '{12'd5,  1'b0, 18'd1, 1'b0, 1'b1, 8'h00, 9'o736};
    vecs[6]  = '{12'd6,  1'b0, 18'd1, 1'b0, 1'b1, 8'h00, 9'o736};
    vecs[7]  = '{12'd7,  1'b0, 18'd1, 1'b1, 1'b1, 8'h00, 9'o736};
    vecs[8]  = '{12'd8,  1'b1, 18'd2, 1'b1, 1'b1, 8'hff, 9'o227};
    vecs[9]  = '{12'd9,  1'b1, 18'd2, 1'b0, 1'b1, 8'hff, 9'o227};
    vecs[10] = '{12'd10, 1'b1, 18'd2, 1'b0, 1'b1, 8'hff, 9'o227};
    vecs[11] = '{12'd11, 1'b1, 18'd2, 1'b1, 1'b1, 8'hff, 9'o227};
    vecs[12] = '{12'd12, 1'b0, 18'd3, 1'b1, 1'b1, 8'h00, 9'o736};
    vecs[13] = '{12'd13, 1'b0, 18'd3, 1'b0, 1'b1, 8'h00, 9'o736};
    vecs[14] = '{12'd14, 1'b0, 18'd3, 1'b0, 1'b1, 8'h00, 9'o736};
    vecs[15] = '{12'd15, 1'b0, 18'd3, 1'b1, 1'b1, 8'h00, 9'o736};

    // Reset state
    cyc(1'b0, 12'd0, 12'd0, 1'b0, 2'b00);
    cyc(1'b0, 12'd0, 12'd0, 1'b0, 2'b00);
    chk("rst_addr", sram_addr, 0);
    chk("rst_we_n", we_n, 1);
    chk("rst_oe_n", oe_n, 0);
    chk("rst_cs_n", cs_n, 0);
    chk("rst_rgb", rgb, 0);
    chk("rst_recording", recording, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;
    cyc(1'b0, 12'd0, 12'd0, 1'b0, 2'b00);
    cyc(1'b0, 12'd0, 12'd0, 1'b0, 2'b00);

    // Record frame: table-driven first 16 pixels of line 0
    we_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, vecs[i].h, 12'd0, vecs[i].pix, 2'b01);
      chk($sformatf("vec%0d_addr", i), sram_addr, vecs[i].addr);
      chk($sformatf("vec%0d_we_n", i), we_n, vecs[i].we_n);
      chk($sformatf("vec%0d_oe_n", i), oe_n, vecs[i].oe_n);
      chk($sformatf("vec%0d_rgb", i), rgb, vecs[i].rgb);
      if (vecs[i].oe_n) chk($sformatf("vec%0d_io", i), sram_io, vecs[i].io);
      if (sram_addr == 18'd2 && !we_n) we_cnt++;
      if (i == 0) chk("rec_recording", recording, 1);
    end
    chk("cell2_strobe_clocks", we_cnt, 2);
    for (int h = 16; h < 32; h++) cyc(1'b1, 12'(h), 12'd0, ((h >> 2) % 2) == 0, 2'b01);
    cyc(1'b0, 12'd32, 12'd0, 1'b0, 2'b01);
    cyc(1'b0, 12'd33, 12'd0, 1'b0, 2'b01);
    for (int c = 0; c < 8; c++)
      chk($sformatf("mem%0d", c), mem[c], (c % 2 == 0) ? 8'hff : 8'h00);

    // Playback: image lags by 5 clocks, alternating palette every 4 pixels
    cyc(1'b1, 12'd0, 12'd0, 1'b0, 2'b10);
    chk("play_recording", recording, 0);
    for (int k = 1; k < 37; k++) begin
      cyc(1'b1, 12'(k), 12'd0, 1'b0, 2'b10);
      if (k >= 5) chk($sformatf("play_rgb_h%0d", k), rgb,
                      ((((k - 5) >> 2) % 2) == 0) ? 9'o357 : 9'o414);
    end
    chk("play_oe_n", oe_n, 0);
    cyc(1'b0, 12'd40, 12'd0, 1'b0, 2'b10);

    // One-shot held for three frames
    fd_cnt = 0;
    cyc(1'b1, 12'd0, 12'd0, 1'b0, 2'b11);
    chk("shot_recording", recording, 1);
    if (frame_done) fd_cnt++;
    for (int k = 1; k < 8; k++) begin
      cyc(1'b1, 12'(k), 12'd0, 1'b0, 2'b11);
      if (frame_done) fd_cnt++;
      if (k == 3) chk("shot_live_rgb", rgb, 9'o736);
    end
    cyc(1'b0, 12'd8, 12'd0, 1'b0, 2'b11);
    cyc(1'b1, 12'd0, 12'd0, 1'b0, 2'b11);
    chk("shot_frame_done", frame_done, 1);
    chk("shot_end_recording", recording, 0);
    if (frame_done) fd_cnt++;
    for (int k = 1; k < 8; k++) begin
      cyc(1'b1, 12'(k), 12'd0, 1'b0, 2'b11);
      if (frame_done) fd_cnt++;
    end
    cyc(1'b1, 12'd0, 12'd0, 1'b0, 2'b11);
    chk("shot_no_rearm", recording, 0);
    if (frame_done) fd_cnt++;
    for (int k = 1; k < 5; k++) begin
      cyc(1'b1, 12'(k), 12'd0, 1'b0, 2'b11);
      if (frame_done) fd_cnt++;
    end
    chk("shot_fd_count", fd_cnt, 1);
    chk("shot_play_oe_n", oe_n, 0);
    chk("shot_mem0", mem[0], 8'h00);

    // Mid-frame request changes are ignored until the next sof
    cyc(1'b1, 12'd10, 12'd300, 1'b0, 2'b01);
    cyc(1'b1, 12'd11, 12'd300, 1'b0, 2'b01);
    cyc(1'b1, 12'd12, 12'd300, 1'b0, 2'b01);
    chk("mid_no_change", recording, 0);
    chk("mid_addr", sram_addr, 15003);
    cyc(1'b1, 12'd0, 12'd0, 1'b0, 2'b01);
    chk("sof_to_rec", recording, 1);
    cyc(1'b1, 12'd10, 12'd300, 1'b0, 2'b00);
    chk("mid_stay_rec", recording, 1);

    // Raster boundaries while recording
    cyc(1'b1, 12'd799, 12'd599, 1'b0, 2'b00);
    chk("last_cell_addr", sram_addr, 29999);
    for (int h = 0; h < 8; h++) begin
      cyc(1'b1, 12'(h), 12'd600, 1'b1, 2'b00);
      chk($sformatf("v600_addr_h%0d", h), sram_addr, 0);
      chk($sformatf("v600_we_n_h%0d", h), we_n, 1);
      chk($sformatf("v600_oe_n_h%0d", h), oe_n, 0);
    end

    // Asynchronous reset in the middle of a write strobe
    cyc(1'b1, 12'd20, 12'd0, 1'b1, 2'b00);
    cyc(1'b1, 12'd21, 12'd0, 1'b1, 2'b00);
    chk("mid_write_we_n", we_n, 0);
    chk("mid_write_io", sram_io, 8'hff);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_we_n", we_n, 1);
    chk("async_rst_oe_n", oe_n, 0);
    chk("async_rst_addr", sram_addr, 0);
    chk("async_rst_rgb", rgb, 0);
    chk("async_rst_recording", recording, 0);
    chk("async_rst_io_released", sram_io, 8'h00);
    cyc(1'b0, 12'd0, 12'd0, 1'b0, 2'b01);
    rst = 1'b0;
    cyc(1'b1, 12'd5, 12'd0, 1'b1, 2'b01);
    chk("post_rst_live", recording, 0);
    chk("post_rst_oe_n", oe_n, 0);
    chk("post_rst_rgb", rgb, 9'o227);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
